// File: rtl/filter2d_pkg.sv
// Shared constants and helpers for the 2D filter datapath (buffer, core, bench).
// Latency: n/a (package only).
// Backpressure: n/a.
package filter2d_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_IMG_W = 256;
    localparam int DEF_IMG_H = 256;

    // Index width for a range of 'depth' entries; never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/filter2d_wr_cnt.sv
// Raster x/y position counter with last-pixel flag and start-of-frame resync.
// Latency: x/y/last describe the current beat combinationally; advance on the en edge.
// Backpressure: none; advances once per en beat.
module filter2d_wr_cnt
    import filter2d_pkg::*;
#(
    parameter int W  = DEF_IMG_W,
    parameter int H  = DEF_IMG_H,
    parameter int XW = addr_w(W),
    parameter int YW = addr_w(H)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          sof,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last,
    output logic          resync
);

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          x_end;
    logic          y_end;

    // A sof beat is placed at the origin regardless of where the counters were.
    assign x      = sof ? '0 : x_q;
    assign y      = sof ? '0 : y_q;
    assign x_end  = (x == XW'(W - 1));
    assign y_end  = (y == YW'(H - 1));
    assign last   = en && x_end && y_end;
    assign resync = en && sof && ((x_q != '0) || (y_q != '0));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en) begin
            if (x_end) begin
                x_q <= '0;
                y_q <= y_end ? '0 : y + 1'b1;
            end else begin
                x_q <= x + 1'b1;
                y_q <= y;
            end
        end
    end

endmodule

// File: rtl/mem_single.sv
// Single-port synchronous RAM with registered read data.
// Latency: rdata valid 1 cycle after a read (cs=1, we=0); rdata holds otherwise.
// Backpressure: none, one access per cycle.
module mem_single #(
    parameter int WD    = 8,
    parameter int DEPTH = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          cs,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [WD-1:0] wdata,
    output logic [WD-1:0] rdata
);

    logic [WD-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (cs) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/filter2d_pp_buf.sv
// Ping-pong frame buffer: fills one bank, hands the full bank to the filter (start), drops frames while busy.
// Latency: bank write 1 cycle after i_strb, start 1 cycle after the last write, rd_data 1 cycle after mem_rd.
// Backpressure: none, 1 pixel/cycle always taken; completed frames are dropped and counted while busy. FILTER2D_BUF_SOF_EN adds i_sof.
module filter2d_pp_buf
    import filter2d_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int AW    = addr_w(IMG_W * IMG_H),
    parameter int CW    = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_strb,
    input  logic [DW-1:0] i_data,
`ifdef FILTER2D_BUF_SOF_EN
    input  logic          i_sof,
`endif
    output logic          start,
    output logic          busy,
    input  logic          rd_done,
    input  logic          mem_rd,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic [CW-1:0] drop_cnt
);

    localparam int XW = addr_w(IMG_W);
    localparam int YW = addr_w(IMG_H);

    logic          mem_wr;
    logic [DW-1:0] wr_data;
    logic          wr_sof;
    logic [XW-1:0] cnt_x;
    logic [YW-1:0] cnt_y;
    logic [AW-1:0] wr_addr;
    logic          fc;
    logic          resync;
    logic          accept;
    logic          drop_frame;
    logic          wr_sel;
    logic          rd_sel_q;
    logic [DW-1:0] bank_q [2];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_wr  <= 1'b0;
            wr_data <= '0;
        end else begin
            mem_wr  <= i_strb;
            wr_data <= i_data;
        end
    end

`ifdef FILTER2D_BUF_SOF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) wr_sof <= 1'b0;
        else       wr_sof <= i_strb && i_sof;
    end
`else
    assign wr_sof = 1'b0;
`endif

    filter2d_wr_cnt #(
        .W (IMG_W),
        .H (IMG_H),
        .XW(XW),
        .YW(YW)
    ) u_wr_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .en    (mem_wr),
        .sof   (wr_sof),
        .x     (cnt_x),
        .y     (cnt_y),
        .last  (fc),
        .resync(resync)
    );

    assign wr_addr = AW'(cnt_y) * AW'(IMG_W) + AW'(cnt_x);

    // A release in the same cycle as frame completion frees the reader first.
    assign accept     = fc && (!busy || rd_done);
    assign drop_frame = fc && busy && !rd_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            start    <= 1'b0;
            busy     <= 1'b0;
            wr_sel   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            start <= accept;
            if (accept) begin
                wr_sel <= ~wr_sel;
                busy   <= 1'b1;
            end else if (rd_done) begin
                busy   <= 1'b0;
            end
            if ((drop_frame || resync) && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Remember which bank a read hit so a swap on the same edge cannot redirect its data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       rd_sel_q <= 1'b0;
        else if (mem_rd) rd_sel_q <= ~wr_sel;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic is_wr;
        assign is_wr = (wr_sel == 1'(b));

        mem_single #(
            .WD   (DW),
            .DEPTH(IMG_W * IMG_H),
            .AW   (AW)
        ) u_mem (
            .clk  (clk),
            .cs   (is_wr ? mem_wr : mem_rd),
            .we   (is_wr && mem_wr),
            .addr (is_wr ? wr_addr : rd_addr),
            .wdata(wr_data),
            .rdata(bank_q[b])
        );
    end

    assign rd_data = bank_q[rd_sel_q];

endmodule

// File: tb/tb_filter2d_pp_buf.sv
// Randomized self-checking bench for filter2d_pp_buf on a 4x2 frame.
// A frame-level model tracks reader ownership, the frame held by the reader and the drop count.
module tb_filter2d_pp_buf;
    import filter2d_pkg::*;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int AW = addr_w(N);
    localparam int CW = 8;
    localparam int DROP_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstn;
    logic          i_strb;
    logic [7:0]    i_data;
`ifdef FILTER2D_BUF_SOF_EN
    logic          i_sof;
`endif
    logic          start;
    logic          busy;
    logic          rd_done;
    logic          mem_rd;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [CW-1:0] drop_cnt;

    filter2d_pp_buf #(
        .DW(8), .IMG_W(W), .IMG_H(H), .CW(CW)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_strb  (i_strb),
        .i_data  (i_data),
`ifdef FILTER2D_BUF_SOF_EN
        .i_sof   (i_sof),
`endif
        .start   (start),
        .busy    (busy),
        .rd_done (rd_done),
        .mem_rd  (mem_rd),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int start_seen = 0;

    // Reference model state
    bit         m_busy;
    int         m_drop;
    int         part_len;
    logic [7:0] m_reader [N];
    logic [7:0] pix [N];

    always @(negedge clk) if (start === 1'b1) start_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void drop_inc();
        if (m_drop < DROP_MAX) m_drop++;
    endfunction

    task automatic fill_pix(input int base);
        for (int i = 0; i < N; i++)
            pix[i] = (base < 0) ? 8'($urandom) : 8'(base + i);
    endtask

    task automatic push_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            i_strb = 1'b1;
            i_data = 8'($urandom);
            tick();
            i_strb = 1'b0;
        end
        part_len += n;
    endtask

    task automatic send_frame(input string tag, input bit gaps, input bit done_at_last,
                              input bit sof_first);
        bit acc;
        int seen0;
        seen0 = start_seen;
        for (int i = 0; i < N; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            i_strb = 1'b1;
            i_data = pix[i];
`ifdef FILTER2D_BUF_SOF_EN
            i_sof  = sof_first && (i == 0);
`endif
            tick();
            i_strb = 1'b0;
`ifdef FILTER2D_BUF_SOF_EN
            i_sof  = 1'b0;
`endif
        end
        if (sof_first && part_len != 0) drop_inc();
        part_len = 0;
        // Now in the cycle of the last bank write.
        acc     = !m_busy || done_at_last;
        rd_done = done_at_last;
        chk({tag, "_start_early"}, 32'(start), 32'd0);
        tick();
        rd_done = 1'b0;
        if (acc) begin
            m_busy   = 1'b1;
            m_reader = pix;
        end else begin
            drop_inc();
        end
        chk({tag, "_start"}, 32'(start), 32'(acc));
        chk({tag, "_busy"}, 32'(busy), 32'(m_busy));
        chk({tag, "_drop"}, 32'(drop_cnt), 32'(m_drop));
        tick();
        chk({tag, "_start_len"}, 32'(start), 32'd0);
        chk({tag, "_start_cnt"}, 32'(start_seen - seen0), 32'(acc));
    endtask

    task automatic read_check(input string tag);
        int off;
        off    = $urandom_range(0, N - 1);
        mem_rd = 1'b1;
        for (int k = 0; k < N; k++) begin
            rd_addr = AW'((off + k) % N);
            tick();
            chk({tag, "_rd"}, 32'(rd_data), 32'(m_reader[(off + k) % N]));
        end
        mem_rd = 1'b0;
        tick();
    endtask

    task automatic release_reader(input string tag);
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        m_busy  = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rstn = 1'b0; i_strb = 1'b0; i_data = '0; rd_done = 1'b0;
        mem_rd = 1'b0; rd_addr = '0;
`ifdef FILTER2D_BUF_SOF_EN
        i_sof = 1'b0;
`endif
        m_busy = 1'b0; m_drop = 0; part_len = 0;
        repeat (3) tick();
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        rstn = 1'b1;
        tick();

        fill_pix(8'h10);
        send_frame("f1", 1'b0, 1'b0, 1'b0);
        read_check("f1");

        fill_pix(8'h20);
        send_frame("f2_drop", 1'b1, 1'b0, 1'b0);
        read_check("f2_keep");

        release_reader("rel1");
        release_reader("rel_idle");

        fill_pix(8'h30);
        send_frame("f3", 1'b1, 1'b0, 1'b0);
        read_check("f3");

        fill_pix(-1);
        send_frame("f4_coinc", 1'b1, 1'b1, 1'b0);
        read_check("f4");

`ifdef FILTER2D_BUF_SOF_EN
        release_reader("rel_sof");
        push_pixels(5);
        fill_pix(-1);
        send_frame("f5_sof", 1'b0, 1'b0, 1'b1);
        read_check("f5");
        release_reader("rel_sof2");
        fill_pix(-1);
        send_frame("f6_sof_nat", 1'b1, 1'b0, 1'b1);
        read_check("f6");
`endif

        for (int f = 0; f < 300; f++) begin
            fill_pix(-1);
            send_frame("sat", 1'b0, 1'b0, 1'b0);
        end
        chk("sat_final", 32'(drop_cnt), 32'(DROP_MAX));
        read_check("sat_keep");

        push_pixels(3);
        #2 rstn = 1'b0;
        #1;
        m_busy = 1'b0; m_drop = 0; part_len = 0;
        chk("mid_rst_start", 32'(start), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        tick();
        rstn = 1'b1;
        tick();
        fill_pix(-1);
        send_frame("post_rst", 1'b1, 1'b0, 1'b0);
        read_check("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
